prim_ram_1p_adapter: RTL and testbench

// - Initiator for a synchronous single-port RAM (1-cycle read latency, req/write/addr/wdata/wmask).
// - Converts a valid/ready host request stream into RAM accesses.
// - Returns read data on a valid/ready response stream through a small response FIFO.
// - Sits between a bus-side host (e.g. TL-UL adapter) and a prim RAM instance.

---
 rtl/prim_ram_1p_adapter.sv | 153 +++++++++++++++
 tb/tb_prim_ram_1p_adapter.sv | 397 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prim_ram_1p_adapter.sv
// Valid/ready host front end for a 1-cycle-latency single-port RAM with a credited response FIFO.
// Define PRIM_RAM_1P_INIT_EN to zero-fill the RAM after reset before host traffic is allowed.
module prim_ram_1p_adapter #(
    parameter  int Width    = 32,
    parameter  int Depth    = 128,
    parameter  int RspDepth = 2,
    localparam int Aw       = $clog2(Depth)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             req_valid_i,
    output logic             req_ready_o,
    input  logic             req_write_i,
    input  logic [Aw-1:0]    req_addr_i,
    input  logic [Width-1:0] req_wdata_i,
    input  logic [Width-1:0] req_wmask_i,
    output logic             rsp_valid_o,
    input  logic             rsp_ready_i,
    output logic [Width-1:0] rsp_rdata_o,
    output logic             ram_req_o,
    output logic             ram_write_o,
    output logic [Aw-1:0]    ram_addr_o,
    output logic [Width-1:0] ram_wdata_o,
    output logic [Width-1:0] ram_wmask_o,
    input  logic [Width-1:0] ram_rdata_i,
    output logic             init_done_o
);

    localparam int Pw = (RspDepth > 1) ? $clog2(RspDepth) : 1;
    localparam int Cw = $clog2(RspDepth + 1);

    logic          run;
    logic          init_done_q;
    logic          sweeping;
    logic [Aw-1:0] sweep_addr;

    assign init_done_o = init_done_q;

`ifdef PRIM_RAM_1P_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    state_t state;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= INIT;
            sweep_addr  <= '0;
            init_done_q <= 1'b0;
        end else begin
            unique case (state)
                INIT: begin
                    if (sweep_addr == Aw'(Depth - 1)) begin
                        state       <= RUN;
                        sweep_addr  <= '0;
                        init_done_q <= 1'b1;
                    end else begin
                        sweep_addr <= sweep_addr + 1'b1;
                    end
                end
                RUN: init_done_q <= 1'b1;
                default: state <= INIT;
            endcase
        end
    end

    assign run      = (state == RUN);
    assign sweeping = (state == INIT) & ~rst_i;
`else
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_done_q <= 1'b0;
        end else begin
            init_done_q <= 1'b1;
        end
    end

    assign run        = init_done_q;
    assign sweeping   = 1'b0;
    assign sweep_addr = '0;
`endif

    logic [Width-1:0] mem [RspDepth];
    logic [Pw-1:0]    wptr;
    logic [Pw-1:0]    rptr;
    logic [Cw-1:0]    cnt;
    logic             inflight;
    logic             push;
    logic             pop;
    logic             host_go;
    logic             rd_go;
    logic             credit_ok;
    logic [Cw:0]      used;

    function automatic logic [Pw-1:0] ptr_next(input logic [Pw-1:0] p);
        return (p == Pw'(RspDepth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign pop  = rsp_valid_o & rsp_ready_i;
    assign push = inflight;

    // A slot freed by this cycle's pop can be reused by this cycle's read.
    assign used = {1'b0, cnt} + {{Cw{1'b0}}, inflight}
                - {{Cw{1'b0}}, pop};
    assign credit_ok = used < (Cw + 1)'(RspDepth);

    assign req_ready_o = run & (req_write_i | credit_ok);
    assign host_go     = req_valid_i & req_ready_o;
    assign rd_go       = host_go & ~req_write_i;

    assign ram_req_o   = sweeping | host_go;
    assign ram_write_o = sweeping ? 1'b1 : req_write_i;
    assign ram_addr_o  = sweeping ? sweep_addr : req_addr_i;
    assign ram_wdata_o = sweeping ? '0 : req_wdata_i;
    assign ram_wmask_o = sweeping ? '1 : req_wmask_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight <= 1'b0;
            wptr     <= '0;
            rptr     <= '0;
            cnt      <= '0;
            for (int i = 0; i < RspDepth; i++) begin
                mem[i] <= '0;
            end
        end else begin
            inflight <= rd_go;
            if (push) begin
                mem[wptr] <= ram_rdata_i;
                wptr      <= ptr_next(wptr);
            end
            if (pop) begin
                rptr <= ptr_next(rptr);
            end
            unique case ({push, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign rsp_valid_o = (cnt != '0);
    assign rsp_rdata_o = rsp_valid_o ? mem[rptr] : '0;

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(push && !pop && cnt == Cw'(RspDepth)));

    a_rsp_stable: assert property (@(posedge clk_i) disable iff (rst_i)
        (rsp_valid_o && !rsp_ready_i) |=> (rsp_valid_o && $stable(rsp_rdata_o)));

    a_init_quiet: assert property (@(posedge clk_i) disable iff (rst_i)
        !(host_go && !run));

endmodule

// File: tb/tb_prim_ram_1p_adapter.sv
// Directed bench for prim_ram_1p_adapter with a behavioural 1-cycle RAM model.
module tb_prim_ram_1p_adapter;

    localparam int W  = 32;
    localparam int D  = 128;
    localparam int AW = 7;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [W-1:0]  req_wdata = '0;
    logic [W-1:0]  req_wmask = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [W-1:0]  rsp_rdata;
    logic          ram_req;
    logic          ram_write;
    logic [AW-1:0] ram_addr;
    logic [W-1:0]  ram_wdata;
    logic [W-1:0]  ram_wmask;
    logic [W-1:0]  ram_rdata;
    logic          init_done;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] ram [D];
    logic [W-1:0] rsp_log [$];
    int           ram_rd_n = 0;

    prim_ram_1p_adapter #(.Width(W), .Depth(D), .RspDepth(2)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_write_i(req_write), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .req_wmask_i(req_wmask),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata),
        .ram_req_o(ram_req), .ram_write_o(ram_write),
        .ram_addr_o(ram_addr), .ram_wdata_o(ram_wdata),
        .ram_wmask_o(ram_wmask), .ram_rdata_i(ram_rdata),
        .init_done_o(init_done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_req) begin
            if (ram_write) begin
                ram[ram_addr] <= (ram[ram_addr] & ~ram_wmask) | (ram_wdata & ram_wmask);
            end else begin
                ram_rdata <= ram[ram_addr];
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (rsp_valid && rsp_ready) rsp_log.push_back(rsp_rdata);
            if (ram_req && !ram_write) ram_rd_n <= ram_rd_n + 1;
        end
    end

    task automatic wr(input logic [AW-1:0] a, input logic [W-1:0] d, input logic [W-1:0] m);
        req_valid = 1'b1; req_write = 1'b1;
        req_addr = a; req_wdata = d; req_wmask = m;
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a);
        req_valid = 1'b1; req_write = 1'b0; req_addr = a;
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_init_done();
        int k;
        for (k = 0; k < 300; k++) begin
            if (init_done) break;
            @(posedge clk); #1;
        end
        checks++;
        if (init_done !== 1'b1) begin
            errors++;
            $display("FAIL wait_init: init_done=%b required 1", init_done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b1; req_write = 1'b1; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL rst_req_ready: got %b required 0", req_ready);
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL rst_rsp_valid: got %b required 0", rsp_valid);
        end
        checks++;
        if (rsp_rdata !== 32'h0) begin
            errors++; $display("FAIL rst_rsp_rdata: got %h required 0", rsp_rdata);
        end
        checks++;
        if (ram_req !== 1'b0) begin
            errors++; $display("FAIL rst_ram_req: got %b required 0", ram_req);
        end
        checks++;
        if (init_done !== 1'b0) begin
            errors++; $display("FAIL rst_init_done: got %b required 0", init_done);
        end
        req_valid = 1'b0; req_write = 1'b0;
        rst = 1'b0;
`ifndef PRIM_RAM_1P_INIT_EN
        @(posedge clk); #1;
        checks++;
        if (init_done !== 1'b1 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL run_after_reset: init_done=%b req_ready=%b required 1 1", init_done, req_ready);
        end
`endif
    endtask

`ifdef PRIM_RAM_1P_INIT_EN
    task automatic test_init();
        int n;
        int bad;
        bit found;
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (ram_req && ram_addr == 7'd40) begin
                found = 1'b1;
                break;
            end
        end
        checks++;
        if (!found) begin
            errors++; $display("FAIL sweep_reach_40: addr=%0d required 40", ram_addr);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (ram_req !== 1'b0 || init_done !== 1'b0) begin
            errors++;
            $display("FAIL sweep_reset: ram_req=%b init_done=%b required 0 0", ram_req, init_done);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (ram_req !== 1'b1 || ram_addr !== 7'd0) begin
            errors++;
            $display("FAIL sweep_restart: ram_req=%b addr=%0d required 1 0", ram_req, ram_addr);
        end
        n = 0; bad = 0;
        req_valid = 1'b1; req_write = 1'b0; req_addr = '0;
        for (int k = 0; k < 400; k++) begin
            if (init_done) break;
            if (req_ready) bad++;
            if (ram_req) begin
                if (!(ram_write && ram_addr == AW'(n) && ram_wdata == 32'h0 && ram_wmask == 32'hFFFF_FFFF))
                    bad++;
                n++;
            end else begin
                bad++;
            end
            @(negedge clk);
        end
        req_valid = 1'b0;
        checks++;
        if (n != D || init_done !== 1'b1) begin
            errors++;
            $display("FAIL sweep_len: writes=%0d done=%b required %0d 1", n, init_done, D);
        end
        checks++;
        if (bad != 0) begin
            errors++; $display("FAIL sweep_content: bad cycles=%0d required 0", bad);
        end
        @(posedge clk); #1;
    endtask
`endif

    task automatic test_raw();
        rsp_ready = 1'b1;
        wr(7'd5, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 7'd5;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL raw_ready: got %b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL raw_early: rsp_valid=%b required 0", rsp_valid);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL raw_data: valid=%b data=%h required 1 deadbeef", rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL raw_pop: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_wmask();
        rsp_ready = 1'b1;
        wr(7'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wr(7'd3, 32'h0000_0000, 32'h0000_FFFF);
        rd(7'd3);
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hFFFF_0000) begin
            errors++;
            $display("FAIL wmask: valid=%b data=%h required 1 ffff0000", rsp_valid, rsp_rdata);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        int base_rd;
        int base;
        int stall;
        logic [W-1:0] got;
        for (int i = 0; i < 8; i++) wr(7'(16 + i), 32'h1000_0000 + i, 32'hFFFF_FFFF);
        rsp_ready = 1'b1;
        base_rd = ram_rd_n; base = rsp_log.size(); stall = 0;
        for (int i = 0; i < 8; i++) begin
            req_valid = 1'b1; req_write = 1'b0; req_addr = 7'(16 + i);
            #1;
            if (req_ready !== 1'b1) stall++;
            @(posedge clk); #1;
        end
        req_valid = 1'b0;
        checks++;
        if (stall != 0) begin
            errors++; $display("FAIL b2b_stall: stalls=%0d required 0", stall);
        end
        checks++;
        if (ram_rd_n - base_rd != 8) begin
            errors++; $display("FAIL b2b_ram_reqs: got %0d required 8", ram_rd_n - base_rd);
        end
        for (int k = 0; k < 20; k++) begin
            if (rsp_log.size() >= base + 8) break;
            @(posedge clk); #1;
        end
        checks++;
        if (rsp_log.size() - base != 8) begin
            errors++; $display("FAIL b2b_count: got %0d required 8", rsp_log.size() - base);
        end
        for (int i = 0; i < 8; i++) begin
            got = (base + i < rsp_log.size()) ? rsp_log[base + i] : 'x;
            checks++;
            if (got !== 32'h1000_0000 + i) begin
                errors++;
                $display("FAIL b2b_data[%0d]: got %h required %h", i, got, 32'h1000_0000 + i);
            end
        end
    endtask

    task automatic test_backpressure();
        int acc;
        int base;
        logic [W-1:0] got;
        rsp_ready = 1'b0; acc = 0;
        req_valid = 1'b1; req_write = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_addr = 7'(20 + acc);
            @(negedge clk);
            if (req_ready) acc++;
            @(posedge clk); #1;
        end
        checks++;
        if (acc != 2) begin
            errors++; $display("FAIL bp_accepted: got %0d required 2", acc);
        end
        checks++;
        if (req_ready !== 1'b0) begin
            errors++; $display("FAIL bp_read_blocked: req_ready=%b required 0", req_ready);
        end
        req_write = 1'b1; req_addr = 7'd30;
        req_wdata = 32'h5A5A_1234; req_wmask = 32'hFFFF_FFFF;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_write_ready: req_ready=%b required 1", req_ready);
        end
        @(posedge clk); #1;
        req_valid = 1'b0; req_write = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h1000_0004) begin
            errors++;
            $display("FAIL bp_head: valid=%b data=%h required 1 10000004", rsp_valid, rsp_rdata);
        end
        base = rsp_log.size();
        rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            if (rsp_log.size() >= base + 2) break;
            @(posedge clk); #1;
        end
        checks++;
        if (rsp_log.size() - base != 2) begin
            errors++; $display("FAIL bp_drain_count: got %0d required 2", rsp_log.size() - base);
        end
        for (int i = 0; i < 2; i++) begin
            got = (base + i < rsp_log.size()) ? rsp_log[base + i] : 'x;
            checks++;
            if (got !== 32'h1000_0004 + i) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got %h required %h", i, got, 32'h1000_0004 + i);
            end
        end
        checks++;
        if (rsp_valid !== 1'b0) begin
            errors++; $display("FAIL bp_empty: rsp_valid=%b required 0", rsp_valid);
        end
    endtask

    task automatic test_reset_mid_read();
        int base;
        int spurious;
        logic [W-1:0] exp30;
`ifdef PRIM_RAM_1P_INIT_EN
        exp30 = 32'h0;
`else
        exp30 = 32'h5A5A_1234;
`endif
        rsp_ready = 1'b1;
        base = rsp_log.size();
        rd(7'd16);
        rst = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || ram_req !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset: valid=%b ram_req=%b ready=%b required 0 0 0", rsp_valid, ram_req, req_ready);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
`ifdef PRIM_RAM_1P_INIT_EN
        wait_init_done();
`else
        @(posedge clk); #1;
`endif
        spurious = 0;
        repeat (4) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0) spurious++;
        end
        @(posedge clk); #1;
        checks++;
        if (spurious != 0 || rsp_log.size() != base) begin
            errors++;
            $display("FAIL mid_no_spurious: cycles=%0d logged=%0d required 0 0", spurious, rsp_log.size() - base);
        end
        rd(7'd30);
        @(posedge clk); #1;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== exp30) begin
            errors++;
            $display("FAIL post_reset_read: valid=%b data=%h required 1 %h", rsp_valid, rsp_rdata, exp30);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: timeout reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
`ifdef PRIM_RAM_1P_INIT_EN
        test_init();
`endif
        test_raw();
        test_wmask();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_read();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
